// File: rtl/systolic_pkg.sv
// Shared types and defaults for the output-stationary systolic array.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DRAIN  = 2'd3
    } sa_state_t;

    localparam int SA_ARRAY_SIZE_DEF = 4;
    localparam int SA_DATA_WIDTH_DEF = 8;
    localparam int SA_ACC_WIDTH_DEF  = 2 * SA_DATA_WIDTH_DEF + 8;

    // Bits needed to hold a counter value in 0..max_val (at least one bit).
    function automatic int sa_cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mac_pe_os.sv
// One output-stationary MAC cell: registers the activation (to the right) and
// the weight (downward) and accumulates their product in place.
module mac_pe_os
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = SA_DATA_WIDTH_DEF,
    parameter int ACC_WIDTH  = SA_ACC_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         i_rst,
    input  logic                         i_clear,
    input  logic signed [DATA_WIDTH-1:0] i_a,
    input  logic signed [DATA_WIDTH-1:0] i_w,
    output logic signed [DATA_WIDTH-1:0] o_a,
    output logic signed [DATA_WIDTH-1:0] o_w,
    output logic signed [ACC_WIDTH-1:0]  o_acc
);

    logic signed [DATA_WIDTH-1:0] r_a;
    logic signed [DATA_WIDTH-1:0] r_w;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic signed [ACC_WIDTH-1:0]  w_a_ext;
    logic signed [ACC_WIDTH-1:0]  w_w_ext;
    logic signed [ACC_WIDTH-1:0]  w_prod;

    // Multiply at accumulator width so the sum wraps modulo 2^ACC_WIDTH.
    assign w_a_ext = ACC_WIDTH'(i_a);
    assign w_w_ext = ACC_WIDTH'(i_w);
    assign w_prod  = w_a_ext * w_w_ext;

    // Operand pass-through and accumulation; clear wins over accumulate.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_a   <= '0;
            r_w   <= '0;
            r_acc <= '0;
        end else begin
            r_a <= i_a;
            r_w <= i_w;
            if (i_clear) begin
                r_acc <= '0;
            end else begin
                r_acc <= r_acc + w_prod;
            end
        end
    end

    assign o_a   = r_a;
    assign o_w   = r_w;
    assign o_acc = r_acc;

endmodule

// File: rtl/systolic_os_array.sv
// Output-stationary N x N systolic matrix-multiply engine: streams K operand
// beats, skews them into the MAC grid, flushes, then drains C row by row.
// Optional build macro SYSTOLIC_RELU_EN clamps negative drained elements to 0.
module systolic_os_array
    import systolic_pkg::*;
#(
    parameter int ARRAY_SIZE = SA_ARRAY_SIZE_DEF,
    parameter int DATA_WIDTH = SA_DATA_WIDTH_DEF,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH + 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             in_last,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] activations,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] weights,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ARRAY_SIZE*ACC_WIDTH-1:0]  out_row,
    output logic                             out_last,
    output logic                             busy
);

    localparam int FLUSH_CW = sa_cnt_width(2 * ARRAY_SIZE - 2);
    localparam int ROW_CW   = sa_cnt_width(ARRAY_SIZE - 1);
    localparam logic [FLUSH_CW-1:0] FLUSH_LOAD = FLUSH_CW'(2 * ARRAY_SIZE - 2);
    localparam logic [ROW_CW-1:0]   ROW_LAST   = ROW_CW'(ARRAY_SIZE - 1);

    sa_state_t             r_state;
    sa_state_t             w_next_state;
    logic [FLUSH_CW-1:0]   r_flush_cnt;
    logic [ROW_CW-1:0]     r_row;
    logic                  w_accept;
    logic                  w_clear;
    logic                  w_row_fire;

    logic signed [DATA_WIDTH-1:0] w_a   [ARRAY_SIZE][ARRAY_SIZE+1];
    logic signed [DATA_WIDTH-1:0] w_w   [ARRAY_SIZE+1][ARRAY_SIZE];
    logic signed [ACC_WIDTH-1:0]  w_acc [ARRAY_SIZE][ARRAY_SIZE];

    function automatic logic signed [ACC_WIDTH-1:0] relu_fn(
        input logic signed [ACC_WIDTH-1:0] v
    );
`ifdef SYSTOLIC_RELU_EN
        return v[ACC_WIDTH-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    assign w_accept   = in_valid && in_ready;
    assign w_clear    = w_accept && (r_state == IDLE);
    assign w_row_fire = out_valid && out_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Flush down-counter (2N-1 cycles lets the last skewed beat reach cell N-1,N-1)
    // and the drain row index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flush_cnt <= '0;
            r_row       <= '0;
        end else begin
            if ((w_next_state == FLUSH) && (r_state != FLUSH)) begin
                r_flush_cnt <= FLUSH_LOAD;
            end else if ((r_state == FLUSH) && (r_flush_cnt != '0)) begin
                r_flush_cnt <= r_flush_cnt - 1'b1;
            end
            if ((r_state == DRAIN) && w_row_fire) begin
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = in_last ? FLUSH : STREAM;
                end
            end
            STREAM: begin
                if (w_accept && in_last) begin
                    w_next_state = FLUSH;
                end
            end
            FLUSH: begin
                if (r_flush_cnt == '0) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (w_row_fire && (r_row == ROW_LAST)) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from registered state only.
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            STREAM: in_ready = 1'b1;
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = (r_row == ROW_LAST);
            end
            default: ;
        endcase
    end

    // Result row mux; zero outside DRAIN so nothing stale leaks out.
    always_comb begin
        out_row = '0;
        if (r_state == DRAIN) begin
            for (int c = 0; c < ARRAY_SIZE; c++) begin
                out_row[c*ACC_WIDTH +: ACC_WIDTH] = relu_fn(w_acc[r_row][c]);
            end
        end
    end

    for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_a_skew
        logic signed [DATA_WIDTH-1:0] r_line [r+1];
        // Capture the activation (zero when no beat is accepted) and delay it r more cycles.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int k = 0; k <= r; k++) r_line[k] <= '0;
            end else begin
                r_line[0] <= w_accept ? activations[r*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int k = 1; k <= r; k++) r_line[k] <= r_line[k-1];
            end
        end
        assign w_a[r][0] = r_line[r];
    end

    for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_w_skew
        logic signed [DATA_WIDTH-1:0] r_line [c+1];
        // Capture the weight (zero when no beat is accepted) and delay it c more cycles.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int k = 0; k <= c; k++) r_line[k] <= '0;
            end else begin
                r_line[0] <= w_accept ? weights[c*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int k = 1; k <= c; k++) r_line[k] <= r_line[k-1];
            end
        end
        assign w_w[0][c] = r_line[c];
    end

    for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_row
        for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_col
            mac_pe_os #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_pe (
                .clk     (clk),
                .i_rst   (reset),
                .i_clear (w_clear),
                .i_a     (w_a[r][c]),
                .i_w     (w_w[r][c]),
                .o_a     (w_a[r][c+1]),
                .o_w     (w_w[r+1][c]),
                .o_acc   (w_acc[r][c])
            );
        end
    end

endmodule
